// File: rtl/argmax_pkg.sv
// Shared types and the single strict-compare rule for the argmax stream.
// ARGMAX_SIGNED_EN switches the compare to two's-complement.
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  // Operands arrive pre-extended (sign or zero) to this width by the caller.
  localparam int CMP_W = 32;

  // True when a strictly beats b; ties never win, so the lowest index is kept.
  function automatic logic better(input logic [CMP_W-1:0] a,
                                  input logic [CMP_W-1:0] b,
                                  input logic             mode);
`ifdef ARGMAX_SIGNED_EN
    if (mode == MODE_MIN) return $signed(a) < $signed(b);
    return $signed(a) > $signed(b);
`else
    if (mode == MODE_MIN) return a < b;
    return a > b;
`endif
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational replace flag: does the candidate strictly beat the current best.
// Sign-extends operands when ARGMAX_SIGNED_EN is defined.
module argmax_cmp
  import argmax_pkg::*;
#(
  parameter int   WIDTH = 3,
  parameter logic MODE  = MODE_MAX
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] best,
  output logic             replace
);

  logic [CMP_W-1:0] cand_x;
  logic [CMP_W-1:0] best_x;

`ifdef ARGMAX_SIGNED_EN
  assign cand_x = CMP_W'($signed(cand));
  assign best_x = CMP_W'($signed(best));
`else
  assign cand_x = CMP_W'(cand);
  assign best_x = CMP_W'(best);
`endif

  assign replace = better(cand_x, best_x, MODE);

endmodule

// File: rtl/argmax_stream.sv
// Streams COUNT values per frame and returns the index/value of the max (or min).
// Signed comparison is selected with ARGMAX_SIGNED_EN.
module argmax_stream #(
  parameter int WIDTH    = 3,
  parameter int COUNT    = 4,
  parameter int IDX_W    = (COUNT > 1) ? $clog2(COUNT) : 1,
  parameter int MODE_MIN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] out_value,
  output logic             busy
);

  import argmax_pkg::state_t;
  import argmax_pkg::IDLE;
  import argmax_pkg::ACCUM;
  import argmax_pkg::DONE;

  localparam logic             CMP_MODE = (MODE_MIN != 0) ? argmax_pkg::MODE_MIN
                                                          : argmax_pkg::MODE_MAX;
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(COUNT - 1);

  state_t           state;
  logic [IDX_W-1:0] count;
  logic [WIDTH-1:0] best_val;
  logic [IDX_W-1:0] best_idx;
  logic             replace;

  argmax_cmp #(
    .WIDTH (WIDTH),
    .MODE  (CMP_MODE)
  ) u_cmp (
    .cand    (in_data),
    .best    (best_val),
    .replace (replace)
  );

  // Held low through the reset cycle and while a result is pending.
  assign in_ready  = !rst && (state != DONE);
  assign out_index = best_idx;
  assign out_value = best_val;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            best_val <= in_data;
            best_idx <= '0;
            count    <= (COUNT == 1) ? '0 : IDX_W'(1);
            if (COUNT == 1) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
              busy  <= 1'b1;
            end
          end
        end
        ACCUM: begin
          // in_data is only looked at on a handshake, so X while idle never leaks.
          if (in_valid) begin
            if (replace) begin
              best_val <= in_data;
              best_idx <= count;
            end
            if (count == LAST) begin
              state     <= DONE;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            count     <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Sequential, parametrised successor to the 4-input combinational comparator.
- Accepts a frame of COUNT unsigned WIDTH-bit values, one per cycle, over a valid/ready stream.
- Returns the index and value of the frame's maximum, or minimum when MODE_MIN=1, over a valid/ready result port.
- Sits between a sample producer and any consumer needing the winner of an N-way comparison.

Parameters:
- WIDTH, 3: bit width of each input value.
- COUNT, 4: values per frame; legal range is 1 or more.
- IDX_W, $clog2(COUNT) with a minimum of 1: width of the index output. Derived; do not override.
- MODE_MIN, 0: 0 selects the maximum; 1 selects the minimum.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  current frame element.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_index  output  IDX_W  position of the winning element within the frame (0-based).
- out_value  output  WIDTH  value of the winning element.
- busy  output  1  a frame is partially accepted.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_index=0, out_value=0, in_ready=0 during the rst cycle, busy=0; internal count=0, state=IDLE.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: best_val<=in_data, best_idx<=0, count<=1.
  - If COUNT==1, go to DONE; otherwise go to ACCUM.
- ACCUM: in_ready=1, busy=1.
  - On each handshake, element number `count` replaces the best if it strictly wins: in_data > best_val when MODE_MIN=0, in_data < best_val when MODE_MIN=1.
  - count increments on each handshake.
  - When the accepted element has count==COUNT-1, go to DONE.
  - No handshake (in_valid=0) holds all state.
- DONE: in_ready=0, out_valid=1; out_index and out_value are stable until the handshake.
  - On out_valid&out_ready, go to IDLE next cycle and clear out_valid.
- Tie rule: strict comparison, so the lowest index among equal winners is reported.
- Latency: out_valid rises on the cycle after the last element is accepted.
- Throughput: COUNT+1 cycles per frame minimum, including one bubble cycle in DONE. Inputs are never accepted while out_valid=1.
- Comparison: unsigned over the full WIDTH; no overflow is possible.
- Index wrap: count never exceeds COUNT-1; it is cleared on re-entry to IDLE.
- out_ready held high in DONE: out_valid is held for exactly 1 cycle.
- out_ready low: the result is held indefinitely and input stays stalled (backpressure).
- Reset mid-frame or in DONE: the partial frame or pending result is discarded. Outputs return to reset values on the next edge, and no stale out_valid is produced.
- in_data is X when in_valid=0: ignored, must not propagate.

Optional Feature:
- Macro: ARGMAX_SIGNED_EN.
- Defined: in_data, out_value and the internal best_val comparison are treated as two's-complement signed. Example: WIDTH=3, value 3'b111 is -1, so it loses to 0 in max mode.
- Undefined: all comparisons are unsigned, as described in Behaviour.
- The tie rule and timing are identical in both cases.

Decomposition:
- Package argmax_pkg holds:
  - the state enum typedef (IDLE, ACCUM, DONE);
  - localparam MODE_MAX=0 and MODE_MIN=1;
  - a function better(a, b, mode) implementing the strict compare, including the signed variant under the macro.
- Sub-module argmax_cmp (combinational, WIDTH-parametrised) wraps better() and returns the replace flag. It is the only compare site, so the signed and min variants live in one place.
- The FSM, counter and result registers stay in argmax_stream.

Test Plan:
- Basic max, WIDTH=3, COUNT=4, frame 1,2,3,4 back-to-back -> out_index=3, out_value=4, out_valid asserted 1 cycle after the 4th accept; frame 5,6,3,4 -> index 1, value 6.
- Ties and gaps: frame 4,4,1,4 with in_valid toggling 1,0,1 -> index 0, value 4; idle cycles hold state, and accepted-element count stays 4.
- Backpressure: frame 1,2,7,0 with out_ready=0 for 5 cycles -> index 2, value 7 held stable; in_ready=0 throughout; next frame 2,4,3,7 accepted only after the handshake -> index 3, value 7.
- MODE_MIN=1: frame 6,3,5,2 -> index 3, value 2; frame 5,1,0,4 -> index 2, value 0; COUNT=1 instance given frame 5 -> index 0, value 5 after 1 cycle.
- Reset: rst pulsed after 2 elements of 7,2,4,5 -> out_valid never asserts for that frame; a fresh frame 4,1,3,2 -> index 0, value 4; rst asserted in DONE -> out_valid=0 next cycle.
- ARGMAX_SIGNED_EN defined, WIDTH=3: frame 7,0,3,4 (that is -1,0,3,-4) -> index 2, value 3; without the macro -> index 0, value 7.
